// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- generic single-clock FIFO with inferred storage.
//
// Holds up to D = 2**FIFO_DEPTH_LOG2 words of FIFO_WIDTH bits between a
// producer and a consumer that share clk. Occupancy, empty/full/almfull are
// all derived from registered state, so no status output has a combinational
// path from write_en/read_en.
//
// Parameters
//   FIFO_WIDTH         data width in bits (>= 1)
//   FIFO_DEPTH_LOG2    log2 of entry count (>= 1)
//   FIFO_ALMFULL_GUARD free-entry guard for almfull, 0..D-1 (0: almfull == full)
//   FIFO_SHOWAHEAD     1: first-word-fall-through, 0: registered read
//
// Ports
//   clk        sole clock, posedge
//   rst        synchronous active-high reset; discards all contents
//   data_in    write data
//   write_en   write request (ignored while full)
//   read_en    read request (ignored while empty)
//   data_out   read data (head word in show-ahead, last read word otherwise)
//   empty      no entries stored
//   full       D entries stored
//   almfull    usedw >= D - FIFO_ALMFULL_GUARD
//   usedw      occupancy 0..D
//   overflow   sticky: write attempted while full
//   underflow  sticky: read attempted while empty
//
// Build option: define SYNC_FIFO_ERR_FLAGS_EN to build the sticky
// overflow/underflow detectors; otherwise both outputs are tied low.

module sync_fifo_param #(
  parameter int FIFO_WIDTH         = 64,
  parameter int FIFO_DEPTH_LOG2    = 6,
  parameter int FIFO_ALMFULL_GUARD = 7,
  parameter int FIFO_SHOWAHEAD     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FIFO_WIDTH-1:0]    data_in,
  input  logic                     write_en,
  input  logic                     read_en,
  output logic [FIFO_WIDTH-1:0]    data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almfull,
  output logic [FIFO_DEPTH_LOG2:0] usedw,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW      = FIFO_DEPTH_LOG2;
  localparam int DEPTH   = 2 ** AW;
  localparam int ALM_LVL = DEPTH - FIFO_ALMFULL_GUARD;

  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
  localparam logic [AW:0] ALM_V   = ALM_LVL[AW:0];

  logic [FIFO_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]   wr_ptr_p0;
  logic [AW:0]   rd_ptr_p0;
  logic [AW:0]   usedw_p0;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          wr_acc;
  logic          rd_acc;

  // Accept decisions use only the registered state, so a write into a full
  // FIFO is dropped even if a read frees a slot on the same edge, and a read
  // of an empty FIFO is dropped even if a write lands on the same edge.
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;
  assign wr_idx = wr_ptr_p0[AW-1:0];
  assign rd_idx = rd_ptr_p0[AW-1:0];

  assign usedw   = usedw_p0;
  assign empty   = (usedw_p0 == '0);
  assign full    = (usedw_p0 == DEPTH_V);
  assign almfull = (usedw_p0 >= ALM_V);

  // ---- stage p0: pointers and occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      usedw_p0  <= '0;
    end else begin
      if (wr_acc) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (rd_acc) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   usedw_p0 <= usedw_p0 + 1'b1;
        2'b01:   usedw_p0 <= usedw_p0 - 1'b1;
        default: usedw_p0 <= usedw_p0;
      endcase
    end
  end

  // Storage carries no reset; rst only blocks the write so a reset cycle
  // never leaves a stray word behind the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_idx] <= data_in;
  end

  // ---- stage p1: read data ----
  generate
    if (FIFO_SHOWAHEAD != 0) begin : g_showahead
      // Head word is presented directly; forced to zero when nothing is
      // stored so stale storage never leaks out.
      assign data_out = empty ? '0 : mem[rd_idx];
    end else begin : g_registered
      logic [FIFO_WIDTH-1:0] dout_p1;
      always_ff @(posedge clk) begin
        if (rst)         dout_p1 <= '0;
        else if (rd_acc) dout_p1 <= mem[rd_idx];
      end
      assign data_out = dout_p1;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_p0;
  logic unf_p0;

  // A read colliding with a write into an empty FIFO is an ordering artifact
  // of the producer/consumer handshake, not a consumer error, so only a
  // lone read of an empty FIFO counts as underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else begin
      if (write_en && full)               ovf_p0 <= 1'b1;
      if (read_en && empty && !write_en)  unf_p0 <= 1'b1;
    end
  end

  assign overflow  = ovf_p0;
  assign underflow = unf_p0;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
